multi_link_ctrl: RTL and testbench

Sequences the two-board multiplayer link. It announces readiness while the local control unit waits for an opponent, and completes a READY/ACK handshake into a one-cycle `opponent_ready` pulse. During play it exchanges loss and heartbeat tokens, and it arbitrates all outgoing tokens onto one byte-wide UART transmit interface. It sits between the game control FSM and the UART TX/RX cores.

---
 rtl/multi_link_pkg.sv | 23 ++
 rtl/link_tx_arbiter.sv | 62 ++++++
 rtl/multi_link_ctrl.sv | 139 +++++++++++++
 tb/tb_multi_link_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_link_pkg.sv
// rtl/multi_link_pkg.sv - link token values, FSM state encoding and tx request flag layout
package multi_link_pkg;

    localparam logic [7:0] TOK_READY = 8'hA5;
    localparam logic [7:0] TOK_ACK   = 8'h5A;
    localparam logic [7:0] TOK_LOST  = 8'hE1;
    localparam logic [7:0] TOK_HB    = 8'h3C;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // One flag per outgoing token, declared in grant priority order
    typedef struct packed {
        logic lost;
        logic ack;
        logic ready;
        logic hb;
    } tx_req_t;

endpackage

// File: rtl/link_tx_arbiter.sv
// rtl/link_tx_arbiter.sv - merges token requests into flags and feeds one byte register to the UART TX
module link_tx_arbiter
    import multi_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  tx_req_t    raise,
    input  logic       clear,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    tx_req_t    pend;
    tx_req_t    grant;
    logic [7:0] sel_data;
    logic       load;

    always_comb begin
        grant    = '0;
        sel_data = TOK_HB;
        if (pend.lost) begin
            grant.lost = 1'b1;
            sel_data   = TOK_LOST;
        end else if (pend.ack) begin
            grant.ack = 1'b1;
            sel_data  = TOK_ACK;
        end else if (pend.ready) begin
            grant.ready = 1'b1;
            sel_data    = TOK_READY;
        end else if (pend.hb) begin
            grant.hb = 1'b1;
            sel_data = TOK_HB;
        end
    end

    assign load = (!tx_valid || tx_ready) && (pend != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            // A raise landing on the grant cycle of the same flag is a fresh request and survives
            if (clear)
                pend <= '0;
            else if (load)
                pend <= tx_req_t'((pend & ~grant) | raise);
            else
                pend <= tx_req_t'(pend | raise);

            if (load) begin
                tx_data  <= sel_data;
                tx_valid <= 1'b1;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_link_ctrl.sv
// rtl/multi_link_ctrl.sv - multiplayer link sequencer; LINK_WATCHDOG_EN adds heartbeat and rx watchdog
module multi_link_ctrl
    import multi_link_pkg::*;
#(
    parameter int RESEND_CYCLES  = 65_000_000 / 10,
    parameter int TIMEOUT_CYCLES = 65_000_000 / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       player_ready,
    input  logic       multiplayer,
    input  logic       game_over_local,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       opponent_ready,
    output logic       opponent_lost,
    output logic       link_timeout,
    output logic [2:0] link_state
);

    localparam int RW = (RESEND_CYCLES > 2) ? $clog2(RESEND_CYCLES) : 1;

    logic [2:0]    state, state_nx;
    logic [RW-1:0] rs_cnt;
    logic          go_prev;
    tx_req_t       raise;
    logic          clear;
    logic          wd_expire;

    wire rx_ready_tok = rx_valid && (rx_data == TOK_READY);
    wire rx_ack_tok   = rx_valid && (rx_data == TOK_ACK);
    wire rx_lost_tok  = rx_valid && (rx_data == TOK_LOST);
    wire go_rise      = game_over_local && !go_prev;
    wire resend_tick  = (rs_cnt == RW'(RESEND_CYCLES - 1));
    wire entering     = (state_nx != state);

`ifdef LINK_WATCHDOG_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wd_cnt;

    assign wd_expire = (state == ST_PLAY) && !rx_valid && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt       <= '0;
            link_timeout <= 1'b0;
        end else begin
            link_timeout <= wd_expire && (state_nx == ST_IDLE);
            if (entering || rx_valid)
                wd_cnt <= '0;
            else if (state == ST_PLAY)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expire    = 1'b0;
    assign link_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        raise    = '0;
        clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (player_ready) begin
                    state_nx    = ST_SYNC;
                    raise.ready = 1'b1;
                end
            end
            ST_SYNC: begin
                if (!player_ready) begin
                    state_nx = ST_IDLE;
                    clear    = 1'b1;
                end else begin
                    raise.ready = resend_tick;
                    if (rx_ready_tok) begin
                        raise.ack = 1'b1;
                        state_nx  = ST_START;
                    end else if (rx_ack_tok) begin
                        state_nx = ST_START;
                    end
                end
            end
            ST_START: state_nx = ST_PLAY;
            ST_PLAY: begin
`ifdef LINK_WATCHDOG_EN
                raise.hb = resend_tick;
`endif
                // Local and remote loss may coincide: both take effect
                raise.lost = go_rise;
                if (go_rise || rx_lost_tok)
                    state_nx = ST_DONE;
                else if (wd_expire || !multiplayer)
                    state_nx = ST_IDLE;
            end
            ST_DONE: begin
                if (!player_ready && !multiplayer)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rs_cnt         <= '0;
            go_prev        <= 1'b0;
            opponent_ready <= 1'b0;
            opponent_lost  <= 1'b0;
        end else begin
            state          <= state_nx;
            go_prev        <= game_over_local;
            opponent_ready <= (state_nx == ST_START) && (state != ST_START);
            opponent_lost  <= (state == ST_PLAY) && rx_lost_tok;
            if (entering || resend_tick)
                rs_cnt <= '0;
            else
                rs_cnt <= rs_cnt + 1'b1;
        end
    end

    assign link_state = state;

    link_tx_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .raise    (raise),
        .clear    (clear),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_multi_link_ctrl.sv
// tb/tb_multi_link_ctrl.sv - randomized scoreboard bench for multi_link_ctrl
module tb_multi_link_ctrl;

    localparam int R = 16;
    localparam int T = 40;
    localparam logic [7:0] K_READY = 8'hA5;
    localparam logic [7:0] K_ACK   = 8'h5A;
    localparam logic [7:0] K_LOST  = 8'hE1;
    localparam logic [7:0] K_HB    = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       player_ready = 1'b0;
    logic       multiplayer = 1'b0;
    logic       game_over_local = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       opponent_ready;
    logic       opponent_lost;
    logic       link_timeout;
    logic [2:0] link_state;

    multi_link_ctrl #(.RESEND_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .player_ready    (player_ready),
        .multiplayer     (multiplayer),
        .game_over_local (game_over_local),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .opponent_ready  (opponent_ready),
        .opponent_lost   (opponent_lost),
        .link_timeout    (link_timeout),
        .link_state      (link_state)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_opp_ready = 0, n_opp_lost = 0, n_timeout = 0;
    int e_opp_ready = 0, e_opp_lost = 0, e_timeout = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (opponent_ready) n_opp_ready++;
            if (opponent_lost)  n_opp_lost++;
            if (link_timeout)   n_timeout++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0)
                    check("tx_unexpected_byte", 32'(tx_data), 32'h100);
                else
                    check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bring IDLE to PLAY; the rx token is sampled w cycles after the edge entering SYNC
    task automatic sync_phase(input int w, input logic [7:0] tok, input bit stall);
        multiplayer  = 1'b1;
        player_ready = 1'b1;
        exp_q.push_back(K_READY);
        for (int k = 1; k * R < w; k++) exp_q.push_back(K_READY);
        if (tok == K_READY) exp_q.push_back(K_ACK);
        if (w % R == 0) exp_q.push_back(K_READY);
        if (stall) begin
            tx_ready = 1'b0;
            cyc(2);
            check("stall_valid", 32'(tx_valid), 1);
            check("stall_data", 32'(tx_data), 32'(K_READY));
            repeat (5) begin
                cyc(1);
                check("stall_hold_valid", 32'(tx_valid), 1);
                check("stall_hold_data", 32'(tx_data), 32'(K_READY));
            end
            tx_ready = 1'b1;
        end else begin
            cyc(w);
        end
        rx_data  = tok;
        rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        e_opp_ready++;
        check("opp_ready_pulse", 32'(opponent_ready), 1);
        check("state_start", 32'(link_state), 2);
        cyc(1);
        check("opp_ready_single", 32'(opponent_ready), 0);
        check("state_play", 32'(link_state), 3);
        player_ready = 1'b0;
    endtask

    // mode 0 local loss, 1 remote loss, 2 both, 3 silent link; called one cycle after PLAY entry
    task automatic play_phase(input int mode, input int d);
        if (mode < 3) begin
`ifdef LINK_WATCHDOG_EN
            for (int k = 1; k * R < d; k++) exp_q.push_back(K_HB);
`endif
            if (mode != 1) exp_q.push_back(K_LOST);
`ifdef LINK_WATCHDOG_EN
            if (d % R == 0) exp_q.push_back(K_HB);
`endif
            if (d > 1) cyc(d - 1);
            if (mode != 1) game_over_local = 1'b1;
            if (mode != 0) begin
                rx_data  = K_LOST;
                rx_valid = 1'b1;
                e_opp_lost++;
            end
            cyc(1);
            rx_valid = 1'b0;
            check("opp_lost_pulse", 32'(opponent_lost), (mode != 0) ? 1 : 0);
            check("state_done", 32'(link_state), 4);
            cyc(1);
            check("opp_lost_single", 32'(opponent_lost), 0);
            cyc(6);
            check("done_holds", 32'(link_state), 4);
            multiplayer     = 1'b0;
            game_over_local = 1'b0;
            cyc(1);
            check("done_to_idle", 32'(link_state), 0);
        end else begin
`ifdef LINK_WATCHDOG_EN
            for (int k = 1; k * R < T; k++) exp_q.push_back(K_HB);
            if (T % R == 0) exp_q.push_back(K_HB);
            cyc(T - 1);
            check("wd_not_yet", 32'(link_timeout), 0);
            check("wd_still_play", 32'(link_state), 3);
            cyc(1);
            e_timeout++;
            check("wd_pulse", 32'(link_timeout), 1);
            check("wd_state_idle", 32'(link_state), 0);
            cyc(1);
            check("wd_single", 32'(link_timeout), 0);
            multiplayer = 1'b0;
`else
            cyc(T + 10);
            check("no_wd_stays_play", 32'(link_state), 3);
            check("no_wd_timeout", 32'(link_timeout), 0);
            multiplayer = 1'b0;
            cyc(1);
            check("mp_low_idle", 32'(link_state), 0);
`endif
        end
        cyc(4);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_state", 32'(link_state), 0);
        check("rst_pulses", 32'({opponent_ready, opponent_lost, link_timeout}), 0);
        rst_n = 1'b1;
        cyc(2);

        sync_phase(3 * R + 1, K_READY, 1'b0);
        play_phase(0, R);
        sync_phase(7, K_ACK, 1'b1);
        play_phase(2, int'($urandom_range(1, 30)));
        sync_phase(int'($urandom_range(2, R)), K_READY, 1'b0);
        play_phase(3, 0);
        for (int i = 0; i < 5; i++) begin
            sync_phase(int'($urandom_range(2, 3 * R + 5)), ($urandom_range(0, 1) != 0) ? K_READY : K_ACK, 1'b0);
            play_phase(int'($urandom_range(0, 3)), int'($urandom_range(1, 30)));
        end

        player_ready = 1'b1;
        multiplayer  = 1'b1;
        tx_ready     = 1'b0;
        cyc(2);
        check("pre_reset_valid", 32'(tx_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(tx_valid), 0);
        check("async_rst_data", 32'(tx_data), 0);
        check("async_rst_state", 32'(link_state), 0);
        check("async_rst_pulses", 32'({opponent_ready, opponent_lost, link_timeout}), 0);
        player_ready = 1'b0;
        multiplayer  = 1'b0;
        tx_ready     = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        check("post_rst_idle", 32'(link_state), 0);
        check("post_rst_valid", 32'(tx_valid), 0);

        check("opp_ready_count", n_opp_ready, e_opp_ready);
        check("opp_lost_count", n_opp_lost, e_opp_lost);
        check("timeout_count", n_timeout, e_timeout);
        check("queue_final", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
